// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed seven-segment display driver.
//
// A prescaler divides clk into digit slots of SCAN_DIV cycles. Slots run from
// digit NUM_DIGITS-1 (leftmost) down to digit 0. At each frame start the
// display inputs are snapshotted, so a whole frame always shows one coherent
// picture. Within a slot the digit enable is PWM-gated by the brightness
// value, and the first cycle of every slot is dark to avoid ghosting.
//
// Parameters:
//   NUM_DIGITS   number of digits, 2..8
//   SCAN_DIV     clk cycles per slot; multiple of 2**BRIGHT_W and >= 2*2**BRIGHT_W
//   BRIGHT_W     brightness control width
//   BLINK_FRAMES frames per blink phase (only with SEVENSEG_BLINK_EN)
//
// Ports:
//   clk, clr     clock; asynchronous active-high reset
//   digits       hex digits, digit i at [4i+3:4i]
//   dp_in        decimal point per digit, 1 = lit
//   blank_in     forced blank per digit, 1 = blank
//   blink_in     blink enable per digit (only with SEVENSEG_BLINK_EN)
//   lz_blank     leading-zero blanking enable
//   brightness   PWM duty, all-ones = maximum
//   seg          segments a..g on seg[6]..seg[0], active-low
//   dp           decimal point, active-low
//   an           digit enables, active-low
//   frame_tick   one-cycle pulse on the first cycle of each frame
//
// Optional feature: define SEVENSEG_BLINK_EN to add per-digit blinking.

module sevenseg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 8192,
  parameter int BRIGHT_W   = 4
`ifdef SEVENSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEVENSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PreLast = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SlotTop = SW'(NUM_DIGITS - 1);

  // Active-low segment pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           pre_q, pre_d;
  logic [SW-1:0]           slot_q, slot_d;
  // Clear until the first frame start: the partial slot after reset stays dark.
  logic                    run_q, run_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [NUM_DIGITS-1:0]   blk_q, blk_d;
  logic                    lz_q, lz_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;

  logic                    wrap;
  logic                    frame_start;
  logic                    blink_blank;

  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    forced;
  logic                    lz_hit;
  logic                    all_zero;
  logic                    blank;
  logic [6:0]              seg_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  // Prescaler, slot index and frame snapshot.
  always_comb begin
    wrap        = (pre_q == PreLast);
    frame_start = wrap && (slot_q == '0);
    pre_d       = wrap ? '0 : pre_q + PW'(1);
    slot_d      = slot_q;
    if (wrap) begin
      slot_d = (slot_q == '0) ? SlotTop : slot_q - SW'(1);
    end
    run_d    = run_q | frame_start;
    dig_d    = dig_q;
    dps_d    = dps_q;
    blk_d    = blk_q;
    lz_d     = lz_q;
    bright_d = bright_q;
    if (frame_start) begin
      dig_d    = digits;
      dps_d    = dp_in;
      blk_d    = blank_in;
      lz_d     = lz_blank;
      bright_d = brightness;
    end
  end

`ifdef SEVENSEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;  // 1 = on phase
  logic [NUM_DIGITS-1:0] blink_q, blink_d;

  // The first frame after reset is frame 0 of the on phase, so the counter only
  // advances at frame starts that follow an earlier frame.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    blink_d = blink_q;
    if (frame_start) begin
      blink_d = blink_in;
      if (run_q) begin
        if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      blink_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  assign blink_blank = ~phase_d & blink_d[slot_d];
`else
  assign blink_blank = 1'b0;
`endif

  // Outputs are computed from next-state values so that the registered seg,
  // dp and an line up with the registered prescaler: slot cycle k == pre_q.
  always_comb begin
    nib      = '0;
    dp_sel   = 1'b0;
    forced   = 1'b0;
    lz_hit   = 1'b0;
    all_zero = lz_d;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (dig_d[4*i +: 4] == 4'h0);
      if (slot_d == SW'(i)) begin
        nib    = dig_d[4*i +: 4];
        dp_sel = dps_d[i];
        forced = blk_d[i];
        lz_hit = all_zero && (i != 0);
      end
    end
    blank = ~run_d | forced | lz_hit | blink_blank;

    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (!blank) begin
      seg_d = hex_to_seg(nib);
      dp_d  = ~dp_sel;
      // Cycle 0 of each slot is dead; the rest is PWM-gated by brightness.
      if ((pre_d != '0) && (pre_d[BRIGHT_W-1:0] <= bright_d)) begin
        an_d = ~(NUM_DIGITS'(1) << slot_d);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_q      <= '0;
      slot_q     <= '0;
      run_q      <= 1'b0;
      dig_q      <= '0;
      dps_q      <= '0;
      blk_q      <= '0;
      lz_q       <= 1'b0;
      bright_q   <= '0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      slot_q     <= slot_d;
      run_q      <= run_d;
      dig_q      <= dig_d;
      dps_q      <= dps_d;
      blk_q      <= blk_d;
      lz_q       <= lz_d;
      bright_q   <= bright_d;
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver with NUM_DIGITS=4, SCAN_DIV=16,
// BRIGHT_W=2. Outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_sevenseg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
`ifdef SEVENSEG_BLINK_EN
  logic [3:0]  blink_in;
`endif
  logic        lz_blank;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // One captured frame plus the first sample of the following frame.
  logic [6:0] cap_seg [65];
  logic       cap_dp  [65];
  logic [3:0] cap_an  [65];
  logic       cap_ft  [65];

  always #5 clk = ~clk;

  sevenseg_scan_driver #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD),
    .BRIGHT_W  (BW)
`ifdef SEVENSEG_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .digits    (digits),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
`ifdef SEVENSEG_BLINK_EN
    .blink_in  (blink_in),
`endif
    .lz_blank  (lz_blank),
    .brightness(brightness),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  // Waits for the next frame_tick; cycles = falling edges waited, -1 on timeout.
  task automatic wait_tick(output int cycles, output logic an_seen);
    cycles  = -1;
    an_seen = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        cycles = n;
        break;
      end
      if (an !== 4'hF) an_seen = 1'b1;
    end
  endtask

  // Call on the falling edge where frame_tick is high.
  task automatic capture_frame();
    for (int j = 0; j <= 64; j++) begin
      if (j != 0) @(negedge clk);
      cap_seg[j] = seg;
      cap_dp[j]  = dp;
      cap_an[j]  = an;
      cap_ft[j]  = frame_tick;
    end
  endtask

  task automatic test_reset();
    int   cyc;
    logic seen;
    clr = 1'b0;
    #2 clr = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL reset_seg: got %h, want 7f", seg);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++; $display("FAIL reset_dp: got %b, want 1", dp);
    end
    checks++;
    if (an !== 4'hF) begin
      errors++; $display("FAIL reset_an: got %b, want 1111", an);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %b, want 0", frame_tick);
    end
    clr = 1'b0;
    wait_tick(cyc, seen);
    checks++;
    if (cyc !== 16) begin
      errors++; $display("FAIL reset_first_tick: got %0d cycles, want 16", cyc);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_dark_slot: got an active before first frame, want none");
    end
  endtask

  task automatic test_basic();
    int         cyc, s, k;
    logic       seen;
    logic [6:0] es [4];
    logic [3:0] ea;
    logic       ed;
    es = '{7'h4C, 7'h06, 7'h12, 7'h4F};  // slot 0..3 show 4,3,2,1
    digits = 16'h1234; brightness = 2'd3; lz_blank = 1'b0;
    dp_in = 4'b0100; blank_in = 4'b0000;
    wait_tick(cyc, seen);
    checks++;
    if (cyc < 0) begin
      errors++; $display("FAIL basic_tick: got timeout, want frame_tick");
    end
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      s  = 3 - j / 16;
      k  = j % 16;
      ea = (k == 0) ? 4'hF : ~(4'b0001 << s);
      ed = (s == 2) ? 1'b0 : 1'b1;
      checks++;
      if (cap_seg[j] !== es[s]) begin
        errors++; $display("FAIL basic_seg j=%0d: got %h, want %h", j, cap_seg[j], es[s]);
      end
      checks++;
      if (cap_an[j] !== ea) begin
        errors++; $display("FAIL basic_an j=%0d: got %b, want %b", j, cap_an[j], ea);
      end
      checks++;
      if (cap_dp[j] !== ed) begin
        errors++; $display("FAIL basic_dp j=%0d: got %b, want %b", j, cap_dp[j], ed);
      end
      checks++;
      if (cap_ft[j] !== (j == 0)) begin
        errors++; $display("FAIL basic_ft j=%0d: got %b, want %b", j, cap_ft[j], j == 0);
      end
    end
    checks++;
    if (cap_ft[64] !== 1'b1) begin
      errors++; $display("FAIL basic_period: got %b at cycle 64, want 1", cap_ft[64]);
    end
  endtask

  task automatic test_blanking();
    int          cyc, s, k;
    logic        seen;
    logic [15:0] cd [3];
    logic        clz [3];
    logic [3:0]  cbl [3];
    logic [6:0]  es [3][4];
    logic [3:0]  eb [3];
    logic [3:0]  ea;
    cd  = '{16'h0050, 16'h0000, 16'h1234};
    clz = '{1'b1, 1'b1, 1'b0};
    cbl = '{4'b0000, 4'b0000, 4'b0010};
    es[0] = '{7'h01, 7'h24, 7'h7F, 7'h7F};
    es[1] = '{7'h01, 7'h7F, 7'h7F, 7'h7F};
    es[2] = '{7'h4C, 7'h7F, 7'h12, 7'h4F};
    eb  = '{4'b1100, 4'b1110, 4'b0010};
    brightness = 2'd3; dp_in = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      digits = cd[c]; lz_blank = clz[c]; blank_in = cbl[c];
      wait_tick(cyc, seen);
      checks++;
      if (cyc < 0) begin
        errors++; $display("FAIL blank_tick case %0d: got timeout, want frame_tick", c);
      end
      capture_frame();
      for (int j = 0; j < 64; j++) begin
        s  = 3 - j / 16;
        k  = j % 16;
        ea = (eb[c][s] || k == 0) ? 4'hF : ~(4'b0001 << s);
        checks++;
        if (cap_seg[j] !== es[c][s]) begin
          errors++;
          $display("FAIL blank_seg case %0d j=%0d: got %h, want %h", c, j, cap_seg[j], es[c][s]);
        end
        checks++;
        if (cap_an[j] !== ea) begin
          errors++; $display("FAIL blank_an case %0d j=%0d: got %b, want %b", c, j, cap_an[j], ea);
        end
        checks++;
        if (cap_dp[j] !== eb[c][s]) begin
          errors++;
          $display("FAIL blank_dp case %0d j=%0d: got %b, want %b", c, j, cap_dp[j], eb[c][s]);
        end
      end
    end
    blank_in = 4'b0000; lz_blank = 1'b0; dp_in = 4'b0000;
  endtask

  task automatic test_brightness();
    int         cyc, s, k;
    logic       seen;
    logic [3:0] ea;
    digits = 16'h1234;
    for (int b = 0; b < 2; b++) begin
      brightness = 2'(b);
      wait_tick(cyc, seen);
      checks++;
      if (cyc < 0) begin
        errors++; $display("FAIL bright_tick b=%0d: got timeout, want frame_tick", b);
      end
      capture_frame();
      for (int j = 0; j < 64; j++) begin
        s  = 3 - j / 16;
        k  = j % 16;
        ea = (k != 0 && (k % 4) <= b) ? ~(4'b0001 << s) : 4'hF;
        checks++;
        if (cap_an[j] !== ea) begin
          errors++; $display("FAIL bright_an b=%0d j=%0d: got %b, want %b", b, j, cap_an[j], ea);
        end
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_midframe();
    int         cyc;
    logic       seen;
    logic [6:0] es_old [4];
    logic [6:0] es_new [4];
    es_old = '{7'h4C, 7'h06, 7'h12, 7'h4F};
    es_new = '{7'h42, 7'h31, 7'h60, 7'h08};  // slot 0..3 show d,C,b,A
    digits = 16'h1234; brightness = 2'd3;
    wait_tick(cyc, seen);
    checks++;
    if (cyc < 0) begin
      errors++; $display("FAIL mid_tick: got timeout, want frame_tick");
    end
    for (int j = 1; j < 64; j++) begin
      @(negedge clk);
      if (j == 20) digits = 16'hABCD;
      if (j >= 20) begin
        checks++;
        if (seg !== es_old[3 - j / 16]) begin
          errors++; $display("FAIL mid_old j=%0d: got %h, want %h", j, seg, es_old[3 - j / 16]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++; $display("FAIL mid_next_tick: got %b, want 1", frame_tick);
    end
    capture_frame();
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (cap_seg[j] !== es_new[3 - j / 16]) begin
        errors++;
        $display("FAIL mid_new j=%0d: got %h, want %h", j, cap_seg[j], es_new[3 - j / 16]);
      end
    end
    digits = 16'h1234;
  endtask

  task automatic test_clr_mid();
    int   cyc;
    logic seen;
    digits = 16'h1234; brightness = 2'd3;
    wait_tick(cyc, seen);
    checks++;
    if (cyc < 0) begin
      errors++; $display("FAIL clr_tick: got timeout, want frame_tick");
    end
    repeat (39) @(negedge clk);  // slot 1, k=7
    checks++;
    if (an !== 4'b1101) begin
      errors++; $display("FAIL clr_pre_an: got %b, want 1101", an);
    end
    #1 clr = 1'b1;
    #1;
    checks++;
    if (seg !== 7'h7F) begin
      errors++; $display("FAIL clr_async_seg: got %h, want 7f", seg);
    end
    checks++;
    if (an !== 4'hF) begin
      errors++; $display("FAIL clr_async_an: got %b, want 1111", an);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++; $display("FAIL clr_async_dp: got %b, want 1", dp);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++; $display("FAIL clr_async_tick: got %b, want 0", frame_tick);
    end
    repeat (3) @(negedge clk);
    clr = 1'b0;
    wait_tick(cyc, seen);
    checks++;
    if (cyc !== 16) begin
      errors++; $display("FAIL clr_first_tick: got %0d cycles, want 16", cyc);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL clr_partial_slot: got an active before frame, want none");
    end
    capture_frame();
    checks++;
    if (cap_an[1] !== 4'b0111) begin
      errors++; $display("FAIL clr_resume_an: got %b, want 0111", cap_an[1]);
    end
    checks++;
    if (cap_seg[1] !== 7'h4F) begin
      errors++; $display("FAIL clr_resume_seg: got %h, want 4f", cap_seg[1]);
    end
  endtask

`ifdef SEVENSEG_BLINK_EN
  task automatic test_blink();
    int         cyc;
    logic       seen;
    logic [3:0] ea;
    logic [6:0] es;
    digits = 16'h1234; brightness = 2'd3; blink_in = 4'b0001;
    #1 clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int f = 0; f < 8; f++) begin
      wait_tick(cyc, seen);
      checks++;
      if (cyc < 0) begin
        errors++; $display("FAIL blink_tick f=%0d: got timeout, want frame_tick", f);
      end
      repeat (49) @(negedge clk);  // slot 0, k=1
      ea = ((f % 4) < 2) ? 4'b1110 : 4'hF;
      es = ((f % 4) < 2) ? 7'h4C : 7'h7F;
      checks++;
      if (an !== ea) begin
        errors++; $display("FAIL blink_an f=%0d: got %b, want %b", f, an, ea);
      end
      checks++;
      if (seg !== es) begin
        errors++; $display("FAIL blink_seg f=%0d: got %h, want %h", f, seg, es);
      end
    end
    blink_in = 4'b0000;
  endtask
`endif

  initial begin
    clr = 1'b0; digits = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000;
    lz_blank = 1'b0; brightness = 2'd3;
`ifdef SEVENSEG_BLINK_EN
    blink_in = 4'b0000;
`endif
    test_reset();
    test_basic();
    test_blanking();
    test_brightness();
    test_midframe();
    test_clr_mid();
`ifdef SEVENSEG_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 The block SHALL have parameter SCAN_DIV, default 8192: clk cycles per digit slot; it SHALL be a multiple of 2^BRIGHT_W and at least 2*2^BRIGHT_W.
REQ-003 The block SHALL have parameter BRIGHT_W, default 4: width of the brightness control.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-high.
- digits  in  4*NUM_DIGITS  hex values; digit i at [4i+3:4i]; digit NUM_DIGITS-1 is leftmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  forced blank per digit, 1 = blank.
- lz_blank  in  1  leading-zero blanking enable.
- brightness  in  BRIGHT_W  PWM duty select, all-ones = maximum.
- seg  out  7  segments a..g on seg[6]..seg[0], active-low.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  digit enables, active-low; an[i] drives digit i.
- frame_tick  out  1  one-cycle pulse at each frame snapshot.

Function
REQ-005 The block SHALL run entirely on clk, SHALL NOT derive clocks, and seg, dp, an and frame_tick SHALL each be driven directly from flops.
REQ-006 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; each wrap SHALL end one slot and advance the slot index from NUM_DIGITS-1 down to 0, wrapping 0 -> NUM_DIGITS-1.
REQ-007 Each wrap to NUM_DIGITS-1 (frame start) SHALL snapshot digits, dp_in, blank_in, lz_blank and brightness, and SHALL pulse frame_tick for exactly that cycle.
REQ-008 The whole frame SHALL be displayed from the snapshot; input changes mid-frame SHALL NOT affect the display until the next frame start.
REQ-009 seg SHALL use this lit-segment decode: 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
REQ-010 Leading-zero blanking: when lz_blank=1, a digit SHALL be blanked if it and every higher digit are 0; digit 0 SHALL never be leading-zero blanked.
REQ-011 A blanked digit (blank_in, leading-zero or blink) SHALL drive seg=7'h7F, dp=1 and keep all an inactive for its slot.
REQ-012 Slot cycle k (0..SCAN_DIV-1) SHALL count from the first cycle that seg shows the slot's digit.
REQ-013 an[idx] SHALL be active at cycle k iff k!=0 and (k mod 2^BRIGHT_W) <= brightness; k=0 is a dead cycle with all an inactive, giving anti-ghosting.
REQ-014 At most one an bit SHALL ever be active.

Reset
REQ-015 clr=1 SHALL immediately force: seg=7'h7F, dp=1, an all ones, frame_tick=0, prescaler=0, slot index=0, snapshot=0.
REQ-016 After clr deasserts, the first frame_tick SHALL occur on the SCAN_DIV-th clk edge, followed by slot NUM_DIGITS-1.
REQ-017 clr asserted mid-slot or mid-frame SHALL abandon the frame with no partial slot completed after release.

Configuration
REQ-018 When SEVENSEG_BLINK_EN is defined, the block SHALL add input port blink_in (NUM_DIGITS wide) and parameter BLINK_FRAMES (default 32).
REQ-019 With SEVENSEG_BLINK_EN defined, a frame counter SHALL toggle the blink phase every BLINK_FRAMES frames, with phase = on after reset.
REQ-020 With SEVENSEG_BLINK_EN defined, digits whose snapshotted blink_in bit is 1 SHALL be blanked during the off phase.
REQ-021 Without SEVENSEG_BLINK_EN, the port, parameter and counter SHALL be absent and the display behaviour SHALL be otherwise identical.

Verification
All scenarios use NUM_DIGITS=4, SCAN_DIV=16, BRIGHT_W=2.
REQ-022 digits=16'h1234, brightness=3, lz_blank=0 -> an cycles 0111, 1011, 1101, 1110, each active at k=1..15; digit "1" drives seg=7'b1001111; frame_tick every 64 cycles.
REQ-023 digits=16'h0050, lz_blank=1 -> slots 3 and 2 have an=1111; digit 1 seg=7'b0100100; digit 0 seg=7'b0000001; with digits=16'h0000, only digit 0 is shown.
REQ-024 brightness=0 -> within each slot, an is active only at k=4, 8, 12.
REQ-025 Change digits from 16'h1234 to 16'hABCD during slot 2 -> slots 1 and 0 still show 3 and 4; A..D appear only after the next frame_tick.
REQ-026 clr pulsed at slot 1, k=7 -> outputs reach reset values in the same cycle with no clk edge; first frame_tick occurs 16 cycles after release.
REQ-027 With SEVENSEG_BLINK_EN, BLINK_FRAMES=2 and blink_in=4'b0001 -> digit 0 is shown in frames 0, 1, 4, 5 and blanked in frames 2, 3, 6, 7.
